// File: rtl/compare_sort_ctrl_if.sv
// Producer/consumer streams and status for the block sorter.
// slave = sorter side, master = environment side.
interface compare_sort_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic [7:0] swap_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, swap_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, swap_count
    );
endinterface

// File: rtl/compare_sort_ctrl.sv
// Block sorter: loads N nibbles, bubble-sorts them through one shared
// comparator at one compare per cycle, then streams the block out.
module magnitude_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       aeqb,
    output logic       agtb,
    output logic       altb
);
    assign aeqb = (a == b);
    assign agtb = (a > b);
    assign altb = (a < b);
endmodule

module compare_sort_ctrl #(
    parameter int N          = 8,
    parameter bit DESCENDING = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    compare_sort_ctrl_if.slave bus
);
    localparam int            PW       = $clog2(N);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [PW-1:0] CMP_END  = PW'(N - 2);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_OUT
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    mem [N];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] idx_p1;
    logic          pass_swapped;
    logic [7:0]    swap_count;
    logic          aeqb, agtb, altb;
    logic          do_swap;
    logic          in_xfer;
    logic          out_xfer;
    logic          pass_end;

    assign idx_p1 = idx + PW'(1);

    magnitude_comparator u_cmp (
        .a    (mem[idx]),
        .b    (mem[idx_p1]),
        .aeqb (aeqb),
        .agtb (agtb),
        .altb (altb)
    );

    // Equal pairs never swap, which keeps the sort stable.
    assign do_swap  = (state == S_SORT) & ~aeqb & (DESCENDING ? altb : agtb);
    assign in_xfer  = (state == S_LOAD) & bus.in_valid;
    assign out_xfer = (state == S_OUT) & bus.out_ready;
    assign pass_end = (idx == CMP_END);

    assign bus.in_ready   = (state == S_LOAD);
    assign bus.out_valid  = (state == S_OUT);
    assign bus.out_data   = (state == S_OUT) ? mem[rd_ptr] : 4'd0;
    assign bus.out_last   = (state == S_OUT) & (rd_ptr == LAST_IDX);
    assign bus.busy       = (state != S_LOAD);
    assign bus.swap_count = swap_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_LOAD: if (in_xfer && wr_ptr == LAST_IDX) state_nx = S_SORT;
            S_SORT: if (pass_end && !pass_swapped && !do_swap) state_nx = S_OUT;
            S_OUT:  if (out_xfer && rd_ptr == LAST_IDX) state_nx = S_LOAD;
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            idx          <= '0;
            pass_swapped <= 1'b0;
            swap_count   <= 8'd0;
        end else begin
            if (in_xfer) begin
                if (wr_ptr == LAST_IDX) begin
                    wr_ptr       <= '0;
                    idx          <= '0;
                    pass_swapped <= 1'b0;
                    swap_count   <= 8'd0;
                end else begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
            if (state == S_SORT) begin
                if (do_swap && swap_count != 8'd255)
                    swap_count <= swap_count + 8'd1;
                if (pass_end) begin
                    idx          <= '0;
                    pass_swapped <= 1'b0;
                end else begin
                    idx          <= idx_p1;
                    pass_swapped <= pass_swapped | do_swap;
                end
            end
            if (out_xfer) begin
                if (rd_ptr == LAST_IDX) rd_ptr <= '0;
                else                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Array contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (in_xfer) mem[wr_ptr] <= bus.in_data;
        if (do_swap) begin
            mem[idx]    <= mem[idx_p1];
            mem[idx_p1] <= mem[idx];
        end
    end
endmodule
